// File: rtl/mem_seq_ctrl_if.sv
// Memory-side bus of mem_seq_ctrl: line address, write line, write enable,
// read-request pulse, read line and the two ready strobes.
//   master : the sequencer (drives address/data/strobes, receives read data
//            and the ready strobes)
//   slave  : the unified memory
interface mem_seq_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int MEM_W  = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic              mem_we;
  logic              mem_rd_start;
  logic [MEM_W-1:0]  mem_rdata;
  logic              mem_rd_rdy;
  logic              mem_wr_rdy;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_rd_start,
    input  mem_rdata, mem_rd_rdy, mem_wr_rdy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_rd_start,
    output mem_rdata, mem_rd_rdy, mem_wr_rdy
  );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Single-port CPU memory sequencer.
// Fetches an instruction line, optionally fetches the data line holding the
// addressed CPU word (skipped on a hit in the one-line buffer), opens a
// two-cycle execute window for the CPU and, for stores, writes the line back
// with one lane replaced. A watchdog bounds every wait on the memory and
// raises a sticky error flag on expiry.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem             memory bus (master side of mem_seq_ctrl_if)
//   prog_addr       instruction line address from the CPU
//   prog_data       registered instruction to the CPU
//   ram_addr        CPU word address (line address plus lane bits)
//   ram_wdata       store data
//   ram_we          store enable, honoured during write-back
//   ram_rdata       registered load data
//   work            CPU execute enable
//   brk             CPU stall/fetch indicator
//   err             sticky bus-timeout flag
module mem_seq_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int CPU_W    = 16,
  parameter int LANES    = 2,
  parameter int PROG_W   = 25,
  parameter int OP_LSB   = 20,
  parameter int OP_W     = 5,
  parameter int OP_LOAD  = 24,
  parameter int OP_STORE = 6,
  parameter int TIMEOUT  = 255,
  localparam int MEM_W   = CPU_W * LANES,
  localparam int LANE_SH = $clog2(LANES),
  localparam int RA_W    = ADDR_W + LANE_SH
) (
  input  logic              clk,
  input  logic              rst,
  mem_seq_ctrl_if.master    mem,
  input  logic [ADDR_W-1:0] prog_addr,
  output logic [PROG_W-1:0] prog_data,
  input  logic [RA_W-1:0]   ram_addr,
  input  logic [CPU_W-1:0]  ram_wdata,
  input  logic              ram_we,
  output logic [CPU_W-1:0]  ram_rdata,
  output logic              work,
  output logic              brk,
  output logic              err
);

  localparam int LANE_W = (LANES > 1) ? LANE_SH : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [OP_W-1:0]  OPC_LOAD  = OP_W'(OP_LOAD);
  localparam logic [OP_W-1:0]  OPC_STORE = OP_W'(OP_STORE);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FWAIT,
    ST_DREQ,
    ST_DWAIT,
    ST_ISSUE,
    ST_EXEC1,
    ST_EXEC2,
    ST_WB
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PROG_W-1:0] ibuf_q;
  logic [RA_W-1:0]   addr_q;
  logic [MEM_W-1:0]  buf_q;
  logic [ADDR_W-1:0] tag_q;
  logic              valid_q;
  logic              err_q;
  logic [PROG_W-1:0] prog_data_q;
  logic [CPU_W-1:0]  ram_rdata_q;

  logic [ADDR_W-1:0] addr_line;
  logic [LANE_W-1:0] addr_lane;
  logic [ADDR_W-1:0] req_line;
  logic [OP_W-1:0]   fetch_op;
  logic [OP_W-1:0]   held_op;
  logic              fetch_is_mem;
  logic              req_hit;
  logic              wait_expired;
  logic [CPU_W-1:0]  buf_lane;
  logic [MEM_W-1:0]  wb_line;

  // Address split: upper bits select the memory line, low bits the lane.
  always_comb begin
    addr_line = addr_q[LANE_SH +: ADDR_W];
    req_line  = ram_addr[LANE_SH +: ADDR_W];
    addr_lane = (LANES > 1) ? addr_q[LANE_W-1:0] : '0;
  end

  always_comb begin
    fetch_op     = mem.mem_rdata[OP_LSB +: OP_W];
    held_op      = ibuf_q[OP_LSB +: OP_W];
    fetch_is_mem = (fetch_op == OPC_LOAD) || (fetch_op == OPC_STORE);
    req_hit      = valid_q && (tag_q == req_line);
    wait_expired = (cnt_q == CNT_LAST);
  end

  // Read-modify-write merge: the buffered line with the addressed lane
  // replaced by the store data.
  always_comb begin
    buf_lane = buf_q[addr_lane * CPU_W +: CPU_W];
    wb_line  = buf_q;
    wb_line[addr_lane * CPU_W +: CPU_W] = ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ibuf_q      <= '0;
      addr_q      <= '0;
      buf_q       <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      prog_data_q <= '0;
      ram_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;

        ST_FETCH: begin
          cnt_q   <= '0;
          state_q <= ST_FWAIT;
        end

        // The hit decision uses the CPU address presented with the
        // instruction, so a hit goes straight to ISSUE without a data read.
        ST_FWAIT: begin
          if (mem.mem_rd_rdy) begin
            ibuf_q <= mem.mem_rdata[PROG_W-1:0];
            addr_q <= ram_addr;
            if (fetch_is_mem && !req_hit) state_q <= ST_DREQ;
            else                          state_q <= ST_ISSUE;
          end else if (wait_expired) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DREQ: begin
          cnt_q   <= '0;
          state_q <= ST_DWAIT;
        end

        ST_DWAIT: begin
          if (mem.mem_rd_rdy) begin
            buf_q   <= mem.mem_rdata;
            tag_q   <= addr_line;
            valid_q <= 1'b1;
            state_q <= ST_ISSUE;
          end else if (wait_expired) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_ISSUE: begin
          prog_data_q <= ibuf_q;
          state_q     <= ST_EXEC1;
        end

        ST_EXEC1: begin
          ram_rdata_q <= buf_lane;
          state_q     <= ST_EXEC2;
        end

        ST_EXEC2: begin
          if (held_op == OPC_STORE) begin
            cnt_q   <= '0;
            state_q <= ST_WB;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        // Keeping the buffer equal to what memory now holds lets a later
        // access to the same line hit without re-reading.
        ST_WB: begin
          if (mem.mem_wr_rdy) begin
            if (ram_we) buf_q <= wb_line;
            state_q <= ST_FETCH;
          end else if (wait_expired) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore decode of the bus and CPU strobes from the current state.
  always_comb begin
    mem.mem_addr     = '0;
    mem.mem_wdata    = '0;
    mem.mem_we       = 1'b0;
    mem.mem_rd_start = 1'b0;
    brk              = 1'b1;
    work             = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem.mem_addr     = prog_addr;
        mem.mem_rd_start = 1'b1;
      end
      ST_DREQ: begin
        mem.mem_addr     = addr_line;
        mem.mem_rd_start = 1'b1;
      end
      ST_ISSUE: brk = 1'b0;
      ST_EXEC1, ST_EXEC2: begin
        brk  = 1'b0;
        work = 1'b1;
      end
      ST_WB: begin
        mem.mem_addr  = addr_line;
        mem.mem_wdata = wb_line;
        mem.mem_we    = ram_we;
      end
      default: ;
    endcase
  end

  assign prog_data = prog_data_q;
  assign ram_rdata = ram_rdata_q;
  assign err       = err_q;

endmodule
